// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU with a one-cycle write-back pulse to the register file.
// Define EXEC_MUL_EN to build the multi-cycle shift-add MUL (opcode 111); otherwise that opcode is dropped.
module exec_unit #(
   parameter int DATA_WIDTH    = 36,
   parameter int ADDRESS_WIDTH = 2,
   parameter int OP_WIDTH      = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [OP_WIDTH-1:0]      i_op,
   input  logic [ADDRESS_WIDTH-1:0] i_rd,
   input  logic [DATA_WIDTH-1:0]    i_rs1_data,
   input  logic [DATA_WIDTH-1:0]    i_rs2_data,
   output logic                     o_wen,
   output logic [ADDRESS_WIDTH-1:0] o_rd,
   output logic [DATA_WIDTH-1:0]    o_wdata,
   output logic                     o_busy,
   output logic                     o_zero,
   output logic [1:0]               o_dbg_state
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [5:0] SHAMT_LIMIT = 6'(DATA_WIDTH);

   localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_SUB = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_AND = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_OR  = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_SLL = 3'd5;
   localparam logic [OP_WIDTH-1:0] OP_SRL = 3'd6;
   localparam logic [OP_WIDTH-1:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Handshake: an op is taken on a rising edge where i_valid and o_ready are both high;
   // upstream holds every input stable until then, and i_valid with o_ready low is ignored.
   state_t                   r_state;
   logic                     r_wen;
   logic [ADDRESS_WIDTH-1:0] r_rd;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic                     r_zero;
   logic                     w_accept;
   logic [5:0]               w_shamt;
   logic [DATA_WIDTH-1:0]    w_alu_result;

   assign w_accept    = i_valid & o_ready;
   assign w_shamt     = i_rs2_data[5:0];
   assign o_ready     = (r_state == ST_IDLE);
   assign o_wen       = r_wen;
   assign o_rd        = r_rd;
   assign o_wdata     = r_wdata;
   assign o_zero      = r_zero;
   assign o_dbg_state = r_state;

   always_comb begin
      w_alu_result = '0;
      case (i_op)
         OP_ADD:  w_alu_result = i_rs1_data + i_rs2_data;
         OP_SUB:  w_alu_result = i_rs1_data - i_rs2_data;
         OP_AND:  w_alu_result = i_rs1_data & i_rs2_data;
         OP_OR:   w_alu_result = i_rs1_data | i_rs2_data;
         OP_XOR:  w_alu_result = i_rs1_data ^ i_rs2_data;
         OP_SLL:  w_alu_result = (w_shamt >= SHAMT_LIMIT) ? '0 : (i_rs1_data << w_shamt);
         OP_SRL:  w_alu_result = (w_shamt >= SHAMT_LIMIT) ? '0 : (i_rs1_data >> w_shamt);
         default: w_alu_result = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   logic [DATA_WIDTH-1:0]    r_mcand;
   logic [DATA_WIDTH-1:0]    r_mplier;
   logic [DATA_WIDTH-1:0]    r_product;
   logic [CNT_W-1:0]         r_count;
   logic [ADDRESS_WIDTH-1:0] r_mul_rd;
   logic [DATA_WIDTH-1:0]    w_product_next;

   // Only the low DATA_WIDTH product bits are ever written back, so no wider accumulator is kept.
   assign w_product_next = r_mplier[0] ? (r_product + r_mcand) : r_product;
   assign o_busy         = (r_state == ST_MUL);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_wen     <= 1'b0;
         r_rd      <= '0;
         r_wdata   <= '0;
         r_zero    <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_product <= '0;
         r_count   <= '0;
         r_mul_rd  <= '0;
      end else begin
         r_wen <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (i_op == OP_MUL) begin
                     r_mcand   <= i_rs1_data;
                     r_mplier  <= i_rs2_data;
                     r_product <= '0;
                     r_count   <= '0;
                     r_mul_rd  <= i_rd;
                     r_state   <= ST_MUL;
                  end else begin
                     r_wen   <= 1'b1;
                     r_rd    <= i_rd;
                     r_wdata <= w_alu_result;
                     r_zero  <= (w_alu_result == '0);
                  end
               end
            end
            ST_MUL: begin
               r_product <= w_product_next;
               r_mcand   <= r_mcand << 1;
               r_mplier  <= r_mplier >> 1;
               r_count   <= r_count + 1'b1;
               // The last iteration's sum goes straight to the write-back registers.
               if (r_count == CNT_W'(DATA_WIDTH - 1)) begin
                  r_state <= ST_WB;
                  r_wen   <= 1'b1;
                  r_rd    <= r_mul_rd;
                  r_wdata <= w_product_next;
                  r_zero  <= (w_product_next == '0);
               end
            end
            ST_WB:   r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
`else
   assign o_busy = 1'b0;

   // Without the multiplier the unit never leaves IDLE; opcode 111 is taken and discarded.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_wen   <= 1'b0;
         r_rd    <= '0;
         r_wdata <= '0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= ST_IDLE;
         r_wen   <= 1'b0;
         if (w_accept && (i_op != OP_MUL)) begin
            r_wen   <= 1'b1;
            r_rd    <= i_rd;
            r_wdata <= w_alu_result;
            r_zero  <= (w_alu_result == '0);
         end
      end
   end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: arithmetic model with an expected write-back queue, checked every cycle,
// plus literal expectations for the directed vectors. Honours EXEC_MUL_EN the same way as the RTL.
module tb_exec_unit;

   localparam int DW = 36;
`ifdef EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic [2:0]    i_op = '0;
   logic [1:0]    i_rd = '0;
   logic [DW-1:0] i_rs1_data = '0;
   logic [DW-1:0] i_rs2_data = '0;
   logic          o_ready;
   logic          o_wen;
   logic [1:0]    o_rd;
   logic [DW-1:0] o_wdata;
   logic          o_busy;
   logic          o_zero;
   logic [1:0]    o_dbg_state;

   exec_unit dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_rd(i_rd), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
      .o_wen(o_wen), .o_rd(o_rd), .o_wdata(o_wdata), .o_busy(o_busy),
      .o_zero(o_zero), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [DW+1:0] exp_q[$];
   logic [1:0]    log_rd[$];
   logic [DW-1:0] log_data[$];
   int            log_cyc[$];
   int            n_checks = 0;
   int            n_pass = 0;
   logic [1:0]    last_rd = '0;
   logic [DW-1:0] last_data = '0;
   logic          last_zero = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Result of an op from plain arithmetic on unsigned integers, reduced modulo 2^36.
   function automatic logic [DW-1:0] model(input int op, input longint unsigned a,
                                           input longint unsigned b);
      longint unsigned m  = 64'hF_FFFF_FFFF;
      longint unsigned sh = b % 64;
      longint unsigned r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (sh >= DW) ? 0 : a * (64'd1 << sh);
         6: r = (sh >= DW) ? 0 : a / (64'd1 << sh);
         default: r = a * b;
      endcase
      return DW'(r & m);
   endfunction

   always @(negedge clk) begin
      logic [DW+1:0] e;
      if (rst) begin
         exp_q.delete();
         last_rd   = '0;
         last_data = '0;
         last_zero = 1'b0;
      end else if (o_wen) begin
         log_rd.push_back(o_rd);
         log_data.push_back(o_wdata);
         log_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("wen_without_op", 64'(o_wen), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 64'(o_rd), 64'(e[DW+1:DW]));
            chk("wb_data", 64'(o_wdata), 64'(e[DW-1:0]));
            chk("wb_zero", 64'(o_zero), 64'(e[DW-1:0] == '0));
            last_rd   = e[DW+1:DW];
            last_data = e[DW-1:0];
            last_zero = (e[DW-1:0] == '0);
         end
      end else begin
         chk("hold_rd", 64'(o_rd), 64'(last_rd));
         chk("hold_data", 64'(o_wdata), 64'(last_data));
         chk("hold_zero", 64'(o_zero), 64'(last_zero));
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input int op, input int rd, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n = 0;
      @(negedge clk);
      i_valid    = 1'b1;
      i_op       = 3'(op);
      i_rd       = 2'(rd);
      i_rs1_data = a;
      i_rs2_data = b;
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         chk("issue_timeout", 64'(o_ready), 64'd1);
      end else begin
         if (!(op == 7 && !MUL_EN)) exp_q.push_back({2'(rd), model(op, 64'(a), 64'(b))});
         @(posedge clk);
      end
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wen"}, 64'(o_wen), 64'd0);
      chk({tag, "_rd"}, 64'(o_rd), 64'd0);
      chk({tag, "_wdata"}, 64'(o_wdata), 64'd0);
      chk({tag, "_zero"}, 64'(o_zero), 64'd0);
      chk({tag, "_ready"}, 64'(o_ready), 64'd1);
      chk({tag, "_busy"}, 64'(o_busy), 64'd0);
   endtask

   // ---------------- directed vector table ----------------
   int            vt_op[8] = '{0, 1, 2, 3, 4, 5, 6, 6};
   int            vt_rd[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   logic [DW-1:0] vt_a[8]  = '{36'h7_0000_0001, 36'h0, 36'hA_5A5A_5A5A, 36'h1_0000_0000,
                               36'hF_FFFF_FFFF, 36'h8_0000_0001, 36'hF_FFFF_FFFF, 36'h1234};
   logic [DW-1:0] vt_b[8]  = '{36'h9_0000_0000, 36'h1, 36'h0_FFFF_0000, 36'h0_0000_0001,
                               36'hF_FFFF_FFFF, 36'h41, 36'd36, 36'd63};

   // ---------------- main sequence ----------------
   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs("reset_init");
      @(negedge clk);
      rst = 1'b0;

      // ADD wrap to zero
      base = log_data.size();
      issue(0, 2, 36'hF_FFFF_FFFF, 36'h1);
      wait_drain();
      chk("add_wrap_count", 64'(log_data.size()), 64'(base + 1));
      if (log_data.size() > base) begin
         chk("add_wrap_data", 64'(log_data[base]), 64'h0);
         chk("add_wrap_rd", 64'(log_rd[base]), 64'd2);
      end
      chk("add_wrap_zero", 64'(o_zero), 64'd1);

      // back-to-back SUB then XOR
      base = log_data.size();
      issue(1, 1, 36'd5, 36'd7);
      issue(4, 3, 36'hF0F, 36'h0FF);
      wait_drain();
      chk("b2b_count", 64'(log_data.size()), 64'(base + 2));
      if (log_data.size() > base + 1) begin
         chk("b2b_sub_data", 64'(log_data[base]), 64'hF_FFFF_FFFE);
         chk("b2b_sub_rd", 64'(log_rd[base]), 64'd1);
         chk("b2b_xor_data", 64'(log_data[base + 1]), 64'hFF0);
         chk("b2b_xor_rd", 64'(log_rd[base + 1]), 64'd3);
         chk("b2b_gap", 64'(log_cyc[base + 1] - log_cyc[base]), 64'd1);
      end

      // shift boundaries
      base = log_data.size();
      issue(5, 0, 36'h1, 36'd36);
      issue(6, 1, 36'h8_0000_0000, 36'd35);
      issue(5, 2, 36'h3, 36'd4);
      wait_drain();
      chk("shift_count", 64'(log_data.size()), 64'(base + 3));
      if (log_data.size() > base + 2) begin
         chk("sll_36", 64'(log_data[base]), 64'h0);
         chk("srl_35", 64'(log_data[base + 1]), 64'h1);
         chk("sll_4", 64'(log_data[base + 2]), 64'h30);
      end

      // table of further ops, issued back-to-back and checked by the model
      for (int i = 0; i < 8; i++) issue(vt_op[i], vt_rd[i], vt_a[i], vt_b[i]);
      wait_drain();

      // asynchronous reset landing in the middle of a write-back pulse
      issue(0, 1, 36'h123, 36'h1);
      #1 chk("pre_reset_wen", 64'(o_wen), 64'd1);
      #1 rst = 1'b1;
      #1 chk_reset_outputs("reset_async");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

`ifdef EXEC_MUL_EN
      base = log_data.size();
      issue(7, 0, 36'd123456, 36'd789);
      for (int c = 1; c <= 38; c++) begin
         @(negedge clk);
         chk("mul_ready", 64'(o_ready), 64'(c == 38));
         chk("mul_wen", 64'(o_wen), 64'(c == 37));
         if (c <= 36) chk("mul_busy", 64'(o_busy), 64'd1);
      end
      chk("mul_count", 64'(log_data.size()), 64'(base + 1));
      if (log_data.size() > base) begin
         chk("mul_data", 64'(log_data[base]), 64'd97406784);
         chk("mul_rd", 64'(log_rd[base]), 64'd0);
      end
      base = log_data.size();
      issue(7, 3, 36'hF_FFFF_FFFF, 36'd2);
      wait_drain();
      chk("mul_wrap_count", 64'(log_data.size()), 64'(base + 1));
      if (log_data.size() > base) chk("mul_wrap_data", 64'(log_data[base]), 64'hF_FFFF_FFFE);
`else
      base = log_data.size();
      issue(7, 0, 36'd123456, 36'd789);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("nomul_ready", 64'(o_ready), 64'd1);
         chk("nomul_wen", 64'(o_wen), 64'd0);
         chk("nomul_busy", 64'(o_busy), 64'd0);
      end
      chk("nomul_count", 64'(log_data.size()), 64'(base));
`endif

      // reset during a MUL abandons it; the next ADD writes back normally
      base = log_data.size();
      issue(7, 2, 36'd5, 36'd7);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("reset_mid_mul");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (45) @(negedge clk);
      chk("abort_no_wb", 64'(log_data.size()), 64'(base));
      issue(0, 1, 36'd2, 36'd3);
      wait_drain();
      chk("post_abort_count", 64'(log_data.size()), 64'(base + 1));
      if (log_data.size() > base) begin
         chk("post_abort_data", 64'(log_data[base]), 64'd5);
         chk("post_abort_rd", 64'(log_rd[base]), 64'd1);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
